// File: rtl/prefix_addsub_pipe_pkg.sv
// ---------------------------------------------------------------------------
// prefix_pkg
// Shared definitions for the pipelined parallel-prefix adder/subtractor.
//   kpg_t         : 2-bit kill/propagate/generate pair
//   KPG_KILL/GEN/PROP : encodings of the pair (01 is never produced)
//   prefix_levels : number of Kogge-Stone levels for a given operand width
// ---------------------------------------------------------------------------
package prefix_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_GEN  = 2'b11;
    localparam kpg_t KPG_PROP = 2'b10;

    // Smallest n with 2**n >= width, i.e. ceil(log2(width)).
    function automatic int prefix_levels(input int width);
        int levels;
        levels = 0;
        while ((1 << levels) < width) begin
            levels = levels + 1;
        end
        return levels;
    endfunction

endpackage

// File: rtl/prefix_addsub_pipe_kpg_merge.sv
// ---------------------------------------------------------------------------
// kpg_merge
// Combinational Kogge-Stone merge cell.
//   i_curr : pair of the more significant group
//   i_prev : pair of the adjacent less significant group
//   o_out  : combined pair; a kill/generate in i_curr decides on its own,
//            a propagate in i_curr passes i_prev through
// ---------------------------------------------------------------------------
module kpg_merge
    import prefix_pkg::*;
(
    input  kpg_t i_curr,
    input  kpg_t i_prev,
    output kpg_t o_out
);

    assign o_out = (i_curr == KPG_PROP) ? i_prev : i_curr;

endmodule

// File: rtl/prefix_addsub_pipe.sv
// ---------------------------------------------------------------------------
// prefix_addsub_pipe
// Fully pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// One beat per cycle; a beat accepted at edge k is presented after edge
// k+LEVELS+1. A stalled output (out_valid & !out_ready) freezes every stage.
//
// Parameters:
//   WIDTH  operand width (power of two, 4..128)
//   TAG_W  width of the sideband tag returned with each result
//   LEVELS derived internally as ceil(log2(WIDTH)); not overridable
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake
//   in_a, in_b           operands
//   in_cin               carry-in for add (ignored when in_sub=1)
//   in_sub               1: A-B, 0: A+B+cin
//   in_tag               sideband tag
//   out_valid/out_ready  output handshake
//   out_sum, out_cout    result and carry-out (subtract: 1 = no borrow)
//   out_tag              tag of the result
//
// Optional build macro PREFIX_ADDSUB_FLAGS_EN adds:
//   out_zero             1 when out_sum == 0
//   out_ovf              signed overflow (carry into MSB xor carry-out)
// ---------------------------------------------------------------------------
module prefix_addsub_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [TAG_W-1:0] out_tag
`ifdef PREFIX_ADDSUB_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_ovf
`endif
);

    localparam int LEVELS = prefix_levels(WIDTH);

    // Position 0 of every kpg vector is the effective carry-in; position
    // i+1 belongs to operand bit i, so after resolution position i holds
    // the carry into bit i and position WIDTH holds the carry-out.
    logic [LEVELS:0]  r_vld;
    logic [WIDTH-1:0] r_x   [0:LEVELS];
    kpg_t [WIDTH:0]   r_kpg [0:LEVELS];
    logic [TAG_W-1:0] r_tag [0:LEVELS];

    logic             w_advance;
    logic [WIDTH-1:0] w_bEff;
    logic [WIDTH-1:0] w_xor0;
    kpg_t [WIDTH:0]   w_kpg0;
    kpg_t [WIDTH:0]   w_lvl [1:LEVELS];
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance && rst_n;

    assign w_bEff = in_sub ? ~in_b : in_b;
    assign w_xor0 = in_a ^ w_bEff;

    // Initial pairs; subtraction is A + ~B + 1, so the carry-in is forced.
    always_comb begin
        w_kpg0    = '0;
        w_kpg0[0] = (in_sub || in_cin) ? KPG_GEN : KPG_KILL;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_a[i] && w_bEff[i]) begin
                w_kpg0[i+1] = KPG_GEN;
            end else if (w_xor0[i]) begin
                w_kpg0[i+1] = KPG_PROP;
            end else begin
                w_kpg0[i+1] = KPG_KILL;
            end
        end
    end

    // Kogge-Stone levels; each level reads the previous stage register.
    for (genvar j = 1; j <= LEVELS; j++) begin : g_level
        localparam int D = 1 << (j - 1);
        for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
            if (i >= D) begin : g_merge
                kpg_merge u_merge (
                    .i_curr (r_kpg[j-1][i]),
                    .i_prev (r_kpg[j-1][i-D]),
                    .o_out  (w_lvl[j][i])
                );
            end else begin : g_pass
                assign w_lvl[j][i] = r_kpg[j-1][i];
            end
        end
    end

    // LEVELS levels span WIDTH positions, one short of the WIDTH+1 needed
    // by the carry-out. Only that top group can still be a propagate, and
    // then its carry is the carry-in held at position 0.
    always_comb begin
        w_carry = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (r_kpg[LEVELS][i] == KPG_PROP) begin
                w_carry[i] = r_kpg[LEVELS][0][0];
            end else begin
                w_carry[i] = r_kpg[LEVELS][i][0];
            end
        end
    end

    assign w_sum = r_x[LEVELS] ^ w_carry[WIDTH-1:0];

    // Stage registers all move together on advance; bubbles travel as
    // cleared valid bits and are never squeezed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            for (int j = 0; j <= LEVELS; j++) begin
                r_x[j]   <= '0;
                r_kpg[j] <= '0;
                r_tag[j] <= '0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_tag   <= '0;
`ifdef PREFIX_ADDSUB_FLAGS_EN
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else if (w_advance) begin
            r_vld[0] <= in_valid;
            r_x[0]   <= w_xor0;
            r_kpg[0] <= w_kpg0;
            r_tag[0] <= in_tag;
            for (int j = 1; j <= LEVELS; j++) begin
                r_vld[j] <= r_vld[j-1];
                r_x[j]   <= r_x[j-1];
                r_kpg[j] <= w_lvl[j];
                r_tag[j] <= r_tag[j-1];
            end
            out_valid <= r_vld[LEVELS];
            out_sum   <= w_sum;
            out_cout  <= w_carry[WIDTH];
            out_tag   <= r_tag[LEVELS];
`ifdef PREFIX_ADDSUB_FLAGS_EN
            out_zero  <= (w_sum == '0);
            out_ovf   <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
`endif
        end
    end

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_prefix_addsub_pipe
// Directed self-checking bench for prefix_addsub_pipe: a 32-bit instance
// for the main scenarios and an 8-bit instance for the narrow full-propagate
// case. Flag checks are compiled in when PREFIX_ADDSUB_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_prefix_addsub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic [3:0]  out_tag;

    logic        s8InValid;
    logic        s8InReady;
    logic [7:0]  s8InA;
    logic [7:0]  s8InB;
    logic        s8InCin;
    logic        s8InSub;
    logic [3:0]  s8InTag;
    logic        s8OutValid;
    logic        s8OutReady;
    logic [7:0]  s8OutSum;
    logic        s8OutCout;
    logic [3:0]  s8OutTag;

`ifdef PREFIX_ADDSUB_FLAGS_EN
    logic        out_zero;
    logic        out_ovf;
    logic        s8OutZero;
    logic        s8OutOvf;
`endif

    int nChecks;
    int nPassed;

    prefix_addsub_pipe #(.WIDTH(32), .TAG_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_tag   (out_tag)
`ifdef PREFIX_ADDSUB_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
`endif
    );

    prefix_addsub_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s8InValid),
        .in_ready  (s8InReady),
        .in_a      (s8InA),
        .in_b      (s8InB),
        .in_cin    (s8InCin),
        .in_sub    (s8InSub),
        .in_tag    (s8InTag),
        .out_valid (s8OutValid),
        .out_ready (s8OutReady),
        .out_sum   (s8OutSum),
        .out_cout  (s8OutCout),
        .out_tag   (s8OutTag)
`ifdef PREFIX_ADDSUB_FLAGS_EN
        ,
        .out_zero  (s8OutZero),
        .out_ovf   (s8OutOvf)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one beat for a single cycle; returns at edge+1 after acceptance.
    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input logic sub, input logic [3:0] tag);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_tag   = tag;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded so a dead pipe cannot hang the run.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Reset values and in_ready held low while rst_n is asserted.
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); else nPassed++;
        nChecks++; if (out_sum !== 32'h0) $display("[TB] FAIL reset_sum got=%h exp=0", out_sum); else nPassed++;
        nChecks++; if (out_cout !== 1'b0) $display("[TB] FAIL reset_cout got=%b exp=0", out_cout); else nPassed++;
        nChecks++; if (out_tag !== 4'h0) $display("[TB] FAIL reset_tag got=%h exp=0", out_tag); else nPassed++;
        nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); else nPassed++;
        nChecks++; if (s8OutValid !== 1'b0) $display("[TB] FAIL reset_valid8 got=%b exp=0", s8OutValid); else nPassed++;
        rst_n = 1'b1;
        #1;
        nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); else nPassed++;
        @(posedge clk);
        #1;
    endtask

    // Single beats through the 32-bit instance, including wrap boundaries.
    task automatic test_arith();
        int lat;
        drive_beat(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd3);
        wait_result(lat);
        nChecks++; if (lat !== 6) $display("[TB] FAIL latency got=%0d exp=6", lat); else nPassed++;
        nChecks++; if (out_sum !== 32'h0) $display("[TB] FAIL wrap_sum got=%h exp=00000000", out_sum); else nPassed++;
        nChecks++; if (out_cout !== 1'b1) $display("[TB] FAIL wrap_cout got=%b exp=1", out_cout); else nPassed++;
        nChecks++; if (out_tag !== 4'd3) $display("[TB] FAIL wrap_tag got=%0d exp=3", out_tag); else nPassed++;
`ifdef PREFIX_ADDSUB_FLAGS_EN
        nChecks++; if (out_zero !== 1'b1) $display("[TB] FAIL wrap_zero got=%b exp=1", out_zero); else nPassed++;
        nChecks++; if (out_ovf !== 1'b0) $display("[TB] FAIL wrap_ovf got=%b exp=0", out_ovf); else nPassed++;
`endif
        @(posedge clk);
        #1;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL single_pulse got=%b exp=0", out_valid); else nPassed++;

        drive_beat(32'h0, 32'h1, 1'b0, 1'b1, 4'd5);
        wait_result(lat);
        nChecks++; if (out_sum !== 32'hFFFF_FFFF) $display("[TB] FAIL borrow_sum got=%h exp=ffffffff", out_sum); else nPassed++;
        nChecks++; if (out_cout !== 1'b0) $display("[TB] FAIL borrow_cout got=%b exp=0", out_cout); else nPassed++;
        nChecks++; if (out_tag !== 4'd5) $display("[TB] FAIL borrow_tag got=%0d exp=5", out_tag); else nPassed++;

        drive_beat(32'h10, 32'h3, 1'b1, 1'b1, 4'd6);
        wait_result(lat);
        nChecks++; if (out_sum !== 32'hD) $display("[TB] FAIL sub_cin_ignored_sum got=%h exp=0000000d", out_sum); else nPassed++;
        nChecks++; if (out_cout !== 1'b1) $display("[TB] FAIL sub_noborrow_cout got=%b exp=1", out_cout); else nPassed++;

        drive_beat(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'd7);
        wait_result(lat);
        nChecks++; if (out_sum !== 32'h2345_678A) $display("[TB] FAIL add_cin_sum got=%h exp=2345678a", out_sum); else nPassed++;
        nChecks++; if (out_cout !== 1'b0) $display("[TB] FAIL add_cin_cout got=%b exp=0", out_cout); else nPassed++;

        drive_beat(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 4'd8);
        wait_result(lat);
        nChecks++; if (out_sum !== 32'h0) $display("[TB] FAIL prop_cin1_sum got=%h exp=00000000", out_sum); else nPassed++;
        nChecks++; if (out_cout !== 1'b1) $display("[TB] FAIL prop_cin1_cout got=%b exp=1", out_cout); else nPassed++;

        drive_beat(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 4'd9);
        wait_result(lat);
        nChecks++; if (out_sum !== 32'hFFFF_FFFF) $display("[TB] FAIL prop_cin0_sum got=%h exp=ffffffff", out_sum); else nPassed++;
        nChecks++; if (out_cout !== 1'b0) $display("[TB] FAIL prop_cin0_cout got=%b exp=0", out_cout); else nPassed++;
        @(posedge clk);
        #1;
    endtask

`ifdef PREFIX_ADDSUB_FLAGS_EN
    // Signed overflow on the positive limit.
    task automatic test_flags();
        int lat;
        drive_beat(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd1);
        wait_result(lat);
        nChecks++; if (out_sum !== 32'h8000_0000) $display("[TB] FAIL ovf_sum got=%h exp=80000000", out_sum); else nPassed++;
        nChecks++; if (out_ovf !== 1'b1) $display("[TB] FAIL ovf_flag got=%b exp=1", out_ovf); else nPassed++;
        nChecks++; if (out_zero !== 1'b0) $display("[TB] FAIL ovf_zero got=%b exp=0", out_zero); else nPassed++;
        @(posedge clk);
        #1;
    endtask
`endif

    // Eight consecutive beats a=i, b=2i must emerge as 3i on consecutive cycles.
    task automatic test_back_to_back();
        int got;
        int firstCyc;
        int lastCyc;
        got      = 0;
        firstCyc = -1;
        lastCyc  = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 8) begin
                in_a     = 32'(cyc);
                in_b     = 32'(2 * cyc);
                in_cin   = 1'b0;
                in_sub   = 1'b0;
                in_tag   = 4'(cyc);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (firstCyc < 0) firstCyc = cyc;
                lastCyc = cyc;
                nChecks++; if (out_sum !== 32'(3 * got)) $display("[TB] FAIL b2b_sum[%0d] got=%0d exp=%0d", got, out_sum, 3 * got); else nPassed++;
                nChecks++; if (out_tag !== 4'(got)) $display("[TB] FAIL b2b_tag[%0d] got=%0d exp=%0d", got, out_tag, got); else nPassed++;
                got++;
            end
        end
        nChecks++; if (got !== 8) $display("[TB] FAIL b2b_count got=%0d exp=8", got); else nPassed++;
        nChecks++; if (firstCyc !== 6) $display("[TB] FAIL b2b_first_cycle got=%0d exp=6", firstCyc); else nPassed++;
        nChecks++; if (lastCyc !== 13) $display("[TB] FAIL b2b_last_cycle got=%0d exp=13", lastCyc); else nPassed++;
    endtask

    // Downstream stall with a continuously valid source, then drain.
    task automatic test_stall();
        int acc;
        int ret;
        int firstRet;
        int lastRet;
        acc      = 0;
        ret      = 0;
        firstRet = -1;
        lastRet  = -1;
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a      = 32'(100 + acc);
            in_b      = 32'(acc);
            in_cin    = 1'b0;
            in_sub    = 1'b0;
            in_tag    = 4'(acc);
            #1;
            if (out_valid) begin
                nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready c=%0d got=%b exp=0", c, in_ready); else nPassed++;
                nChecks++; if (out_sum !== 32'd100) $display("[TB] FAIL stall_hold_sum c=%0d got=%0d exp=100", c, out_sum); else nPassed++;
                nChecks++; if (out_tag !== 4'd0) $display("[TB] FAIL stall_hold_tag c=%0d got=%0d exp=0", c, out_tag); else nPassed++;
            end
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        nChecks++; if (acc !== 7) $display("[TB] FAIL stall_accepted got=%0d exp=7", acc); else nPassed++;
        for (int c = 0; c < 20; c++) begin
            out_ready = 1'b1;
            in_valid  = 1'b0;
            #1;
            if (out_valid) begin
                if (firstRet < 0) firstRet = c;
                lastRet = c;
                nChecks++; if (out_sum !== 32'(100 + 2 * ret)) $display("[TB] FAIL drain_sum[%0d] got=%0d exp=%0d", ret, out_sum, 100 + 2 * ret); else nPassed++;
                nChecks++; if (out_tag !== 4'(ret)) $display("[TB] FAIL drain_tag[%0d] got=%0d exp=%0d", ret, out_tag, ret); else nPassed++;
                ret++;
            end
            @(posedge clk);
            #1;
        end
        nChecks++; if (ret !== 7) $display("[TB] FAIL drain_count got=%0d exp=7", ret); else nPassed++;
        nChecks++; if (lastRet - firstRet !== 6) $display("[TB] FAIL drain_spacing got=%0d exp=6", lastRet - firstRet); else nPassed++;
    endtask

    // Asynchronous reset with one result on the output and four beats behind it.
    task automatic test_reset_midflight();
        int seen;
        seen      = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_a     = 32'h100 + 32'(k);
            in_b     = 32'h23;
            in_cin   = 1'b0;
            in_sub   = 1'b0;
            in_tag   = 4'(k + 1);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL pre_reset_valid got=%b exp=1", out_valid); else nPassed++;
        nChecks++; if (out_sum !== 32'h123) $display("[TB] FAIL pre_reset_sum got=%h exp=00000123", out_sum); else nPassed++;
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL async_reset_valid got=%b exp=0", out_valid); else nPassed++;
        nChecks++; if (out_sum !== 32'h0) $display("[TB] FAIL async_reset_sum got=%h exp=0", out_sum); else nPassed++;
        nChecks++; if (out_tag !== 4'h0) $display("[TB] FAIL async_reset_tag got=%h exp=0", out_tag); else nPassed++;
        nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL async_reset_in_ready got=%b exp=0", in_ready); else nPassed++;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        nChecks++; if (seen !== 0) $display("[TB] FAIL stale_after_reset got=%0d exp=0", seen); else nPassed++;
    endtask

    // Narrow instance: full-propagate chain resolved by the carry-in.
    task automatic test_width8();
        int lat;
        s8InA     = 8'h55;
        s8InB     = 8'hAA;
        s8InCin   = 1'b1;
        s8InSub   = 1'b0;
        s8InTag   = 4'd2;
        s8InValid = 1'b1;
        @(posedge clk);
        #1;
        s8InValid = 1'b0;
        lat = 0;
        while (!s8OutValid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        nChecks++; if (lat !== 4) $display("[TB] FAIL w8_latency got=%0d exp=4", lat); else nPassed++;
        nChecks++; if (s8OutSum !== 8'h00) $display("[TB] FAIL w8_prop_sum got=%h exp=00", s8OutSum); else nPassed++;
        nChecks++; if (s8OutCout !== 1'b1) $display("[TB] FAIL w8_prop_cout got=%b exp=1", s8OutCout); else nPassed++;
        nChecks++; if (s8OutTag !== 4'd2) $display("[TB] FAIL w8_tag got=%0d exp=2", s8OutTag); else nPassed++;

        s8InA     = 8'h10;
        s8InB     = 8'h20;
        s8InCin   = 1'b0;
        s8InSub   = 1'b1;
        s8InValid = 1'b1;
        @(posedge clk);
        #1;
        s8InValid = 1'b0;
        lat = 0;
        while (!s8OutValid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        nChecks++; if (s8OutSum !== 8'hF0) $display("[TB] FAIL w8_sub_sum got=%h exp=f0", s8OutSum); else nPassed++;
        nChecks++; if (s8OutCout !== 1'b0) $display("[TB] FAIL w8_sub_cout got=%b exp=0", s8OutCout); else nPassed++;
    endtask

    // Test sequence.
    initial begin
        nChecks    = 0;
        nPassed    = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        in_sub     = 1'b0;
        in_tag     = '0;
        out_ready  = 1'b1;
        s8InValid  = 1'b0;
        s8InA      = '0;
        s8InB      = '0;
        s8InCin    = 1'b0;
        s8InSub    = 1'b0;
        s8InTag    = '0;
        s8OutReady = 1'b1;

        $display("[TB] start");
        test_reset();
        test_arith();
`ifdef PREFIX_ADDSUB_FLAGS_EN
        test_flags();
`endif
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_width8();

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
